idu_stage: RTL and testbench
============================

IDU_STAGE -- requirements
Module: idu_stage

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: in_valid  input  1  upstream fetch stage presents an instruction.
REQ-004 SHALL: in_ready  output  1  stage can accept an instruction this cycle.
REQ-005 SHALL: in_inst  input  32  raw RV32I instruction word.
REQ-006 SHALL: in_pc  input  32  PC of in_inst.
REQ-007 SHALL: flush  input  1  discard the held and incoming instruction (redirect).
REQ-008 SHALL: out_valid  output  1  decoded bundle valid toward execute stage.
REQ-009 SHALL: out_ready  input  1  execute stage accepts the bundle.
REQ-010 SHALL: out_pc  output  32  registered in_pc.
REQ-011 SHALL: out_rd, out_rs1, out_rs2  output  5 each  inst[11:7], inst[19:15], inst[24:20].
REQ-012 SHALL: out_funct3  output  3  inst[14:12]; out_f7b5  output  1  inst[30].
REQ-013 SHALL: out_imm  output  32  sign-extended immediate per format.
REQ-014 SHALL: out_op  output  4  instruction class code (REQ-018).
REQ-015 SHALL: out_illegal  output  1  unsupported or malformed encoding; out_ebreak  output  1  inst == 0x00100073.

Function
REQ-016 SHALL: Single output pipeline register; in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
REQ-017 SHALL: Accept = in_valid && in_ready && !flush; on accept, decode in_inst combinationally and load all out_* fields at the next clock edge, out_valid <= 1; latency 1 cycle.
REQ-018 SHALL: out_op by opcode inst[6:0]: 0110111 LUI=0, 0010111 AUIPC=1, 1101111 JAL=2, 1100111 JALR=3, 1100011 BRANCH=4, 0000011 LOAD=5, 0100011 STORE=6, 0010011 OPIMM=7, 0110011 OP=8, 1110011 SYSTEM=9, else 15 with out_illegal=1.
REQ-019 SHALL: Immediates: I = sext(inst[31:20]) for JALR/LOAD/OPIMM/SYSTEM; S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); U = {inst[31:12],12'b0}; J = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); OP class imm = 0.
REQ-020 SHALL: out_illegal also 1 when inst[1:0] != 2'b11, JALR funct3 != 0, or OP funct7 not in {0x00,0x20}; illegal instructions still pass downstream with out_valid.
REQ-021 SHALL: Hold: out_valid && !out_ready -> all out_* stable, in_ready=0, no upstream instruction consumed.
REQ-022 SHALL: Handover: out_valid && out_ready && in_valid same cycle -> new bundle loaded, out_valid stays 1 (full throughput, one instruction per cycle).
REQ-023 SHALL: Drain: out_valid && out_ready && !in_valid -> out_valid <= 0; data fields may keep old values.
REQ-024 SHALL: flush priority over every other event: next edge out_valid <= 0, incoming instruction dropped even if in_valid && in_ready; in_ready remains per REQ-016 during the flush cycle.
REQ-025 SHALL: No combinational path from in_inst/in_pc to any out_* signal.

Reset
REQ-026 SHALL: rst at clock edge -> out_valid=0 and all data outputs (out_pc, out_imm, register fields, out_op, flags) = 0; rst overrides accept and flush.
REQ-027 SHALL: rst asserted mid-hold discards the held bundle; in_ready=1 from the first cycle after rst deasserts.

Verification
REQ-028 SHALL: in_inst=0x00500093 (addi x1,x0,5), pc=0x80000000, out_ready=1 -> next cycle out_valid=1, op=7, rd=1, rs1=0, imm=0x00000005, illegal=0.
REQ-029 SHALL: in_inst=0x12345137 (lui x2) -> op=0, rd=2, imm=0x12345000; in_inst=0xFE000EE3 (beq x0,x0,-4) -> op=4, imm=0xFFFFFFFC.
REQ-030 SHALL: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, bundle unchanged; out_ready=1 -> next instruction loaded in the following cycle, none lost or duplicated.
REQ-031 SHALL: flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0, the flushed incoming instruction never appears at the output.
REQ-032 SHALL: in_inst=0xFFFFFFFF -> op=15, illegal=1; in_inst=0x00100073 -> op=9, ebreak=1; in_inst=0x00000013 with inst[1:0] forced to 00 (0x00000010) -> illegal=1.
REQ-033 SHALL: rst pulse while holding a bundle with out_ready=0 -> out_valid=0 and outputs 0 the next cycle, in_ready=1 after release.

Source files
------------

// File: rtl/idu_stage_if.sv
// Handshake and decoded-bundle signals between fetch, decode and execute.
interface idu_stage_if;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned OP_W   = 4;

  // Upstream (fetch) side
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_inst;
  logic [XLEN-1:0]   in_pc;
  logic              flush;

  // Downstream (execute) side
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [REG_W-1:0]  out_rd;
  logic [REG_W-1:0]  out_rs1;
  logic [REG_W-1:0]  out_rs2;
  logic [F3_W-1:0]   out_funct3;
  logic              out_f7b5;
  logic [XLEN-1:0]   out_imm;
  logic [OP_W-1:0]   out_op;
  logic              out_illegal;
  logic              out_ebreak;

  // Environment view: drives instructions and back-pressure, observes the bundle
  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
           out_funct3, out_f7b5, out_imm, out_op, out_illegal, out_ebreak
  );

  // Decode-stage view
  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
           out_funct3, out_f7b5, out_imm, out_op, out_illegal, out_ebreak
  );
endinterface

// File: rtl/idu_stage.sv
// RV32I instruction decode stage: combinational decode of the incoming word
// into a single registered output bundle with valid/ready flow control.
module idu_stage (
  input  logic         clk,
  input  logic         rst,
  idu_stage_if.slave   bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned OP_W  = 4;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Instruction class codes presented on out_op
  localparam logic [OP_W-1:0] CLS_LUI    = 4'd0;
  localparam logic [OP_W-1:0] CLS_AUIPC  = 4'd1;
  localparam logic [OP_W-1:0] CLS_JAL    = 4'd2;
  localparam logic [OP_W-1:0] CLS_JALR   = 4'd3;
  localparam logic [OP_W-1:0] CLS_BRANCH = 4'd4;
  localparam logic [OP_W-1:0] CLS_LOAD   = 4'd5;
  localparam logic [OP_W-1:0] CLS_STORE  = 4'd6;
  localparam logic [OP_W-1:0] CLS_OPIMM  = 4'd7;
  localparam logic [OP_W-1:0] CLS_OP     = 4'd8;
  localparam logic [OP_W-1:0] CLS_SYSTEM = 4'd9;
  localparam logic [OP_W-1:0] CLS_ILL    = 4'd15;

  localparam logic [XLEN-1:0] EBREAK_WORD = 32'h0010_0073;

  // Registered bundle
  logic              valid_q;
  logic [XLEN-1:0]   pc_q;
  logic [REG_W-1:0]  rd_q;
  logic [REG_W-1:0]  rs1_q;
  logic [REG_W-1:0]  rs2_q;
  logic [F3_W-1:0]   funct3_q;
  logic              f7b5_q;
  logic [XLEN-1:0]   imm_q;
  logic [OP_W-1:0]   op_q;
  logic              illegal_q;
  logic              ebreak_q;

  // Decode results for the word currently on in_inst
  logic [XLEN-1:0]   inst;
  logic [6:0]        opcode;
  logic [F3_W-1:0]   funct3;
  logic [6:0]        funct7;
  logic [XLEN-1:0]   imm_i;
  logic [XLEN-1:0]   imm_s;
  logic [XLEN-1:0]   imm_b;
  logic [XLEN-1:0]   imm_u;
  logic [XLEN-1:0]   imm_j;
  logic [OP_W-1:0]   dec_op;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_illegal;
  logic              dec_ebreak;

  logic              in_ready_c;
  logic              accept_c;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Immediate formats, all sign-extended from inst[31] except U
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Class, immediate selection and legality checks
  always_comb begin
    dec_op      = CLS_ILL;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_LUI:    begin dec_op = CLS_LUI;    dec_imm = imm_u; end
      OPC_AUIPC:  begin dec_op = CLS_AUIPC;  dec_imm = imm_u; end
      OPC_JAL:    begin dec_op = CLS_JAL;    dec_imm = imm_j; end
      OPC_JALR: begin
        dec_op  = CLS_JALR;
        dec_imm = imm_i;
        if (funct3 != 3'b000) dec_illegal = 1'b1;
      end
      OPC_BRANCH: begin dec_op = CLS_BRANCH; dec_imm = imm_b; end
      OPC_LOAD:   begin dec_op = CLS_LOAD;   dec_imm = imm_i; end
      OPC_STORE:  begin dec_op = CLS_STORE;  dec_imm = imm_s; end
      OPC_OPIMM:  begin dec_op = CLS_OPIMM;  dec_imm = imm_i; end
      OPC_OP: begin
        dec_op  = CLS_OP;
        dec_imm = '0;
        if ((funct7 != 7'h00) && (funct7 != 7'h20)) dec_illegal = 1'b1;
      end
      OPC_SYSTEM: begin dec_op = CLS_SYSTEM; dec_imm = imm_i; end
      default: begin
        dec_op      = CLS_ILL;
        dec_imm     = '0;
        dec_illegal = 1'b1;
      end
    endcase
    // Compressed / non-32-bit encodings are never accepted
    if (inst[1:0] != 2'b11) dec_illegal = 1'b1;
  end

  assign dec_ebreak = (inst == EBREAK_WORD);

  // Ready depends only on the output register, never on in_valid
  assign in_ready_c = !valid_q || bus.out_ready;
  assign accept_c   = bus.in_valid && in_ready_c && !bus.flush;

  // Output pipeline register: reset > flush > accept > drain > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      funct3_q  <= '0;
      f7b5_q    <= 1'b0;
      imm_q     <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
      ebreak_q  <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept_c) begin
      valid_q   <= 1'b1;
      pc_q      <= bus.in_pc;
      rd_q      <= inst[11:7];
      rs1_q     <= inst[19:15];
      rs2_q     <= inst[24:20];
      funct3_q  <= funct3;
      f7b5_q    <= inst[30];
      imm_q     <= dec_imm;
      op_q      <= dec_op;
      illegal_q <= dec_illegal;
      ebreak_q  <= dec_ebreak;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_rs1     = rs1_q;
  assign bus.out_rs2     = rs2_q;
  assign bus.out_funct3  = funct3_q;
  assign bus.out_f7b5    = f7b5_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_op      = op_q;
  assign bus.out_illegal = illegal_q;
  assign bus.out_ebreak  = ebreak_q;

endmodule

// File: tb/tb_idu_stage.sv
// Directed self-checking bench for idu_stage.
module tb_idu_stage;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  idu_stage_if bus ();

  idu_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Advance one edge; outputs are sampled 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
  endtask

  // Send one instruction with out_ready=1 and check class/imm/illegal
  task automatic dec(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                     input logic [3:0] op, input logic [31:0] imm, input logic ill);
    drive(1'b1, inst, pc);
    tick();
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_pc"}, bus.out_pc, pc);
    check({tag, "_op"}, 32'(bus.out_op), 32'(op));
    check({tag, "_imm"}, bus.out_imm, imm);
    check({tag, "_ill"}, 32'(bus.out_illegal), 32'(ill));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_pc", bus.out_pc, 32'h0);
    check("rst_imm", bus.out_imm, 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // addi x1,x0,5
    dec("addi", 32'h0050_0093, 32'h8000_0000, 4'd7, 32'h0000_0005, 1'b0);
    check("addi_rd", 32'(bus.out_rd), 32'd1);
    check("addi_rs1", 32'(bus.out_rs1), 32'd0);
    // Back-to-back handover, all formats
    dec("lui", 32'h1234_5137, 32'h8000_0004, 4'd0, 32'h1234_5000, 1'b0);
    check("lui_rd", 32'(bus.out_rd), 32'd2);
    dec("beq", 32'hFE00_0EE3, 32'h8000_0008, 4'd4, 32'hFFFF_FFFC, 1'b0);
    dec("auipc", 32'h0000_1097, 32'h8000_000C, 4'd1, 32'h0000_1000, 1'b0);
    dec("jal", 32'h0080_00EF, 32'h8000_0010, 4'd2, 32'h0000_0008, 1'b0);
    dec("sw", 32'hFE20_AE23, 32'h8000_0014, 4'd6, 32'hFFFF_FFFC, 1'b0);
    check("sw_rs2", 32'(bus.out_rs2), 32'd2);
    check("sw_f3", 32'(bus.out_funct3), 32'd2);
    dec("lw", 32'hFF81_2183, 32'h8000_0018, 4'd5, 32'hFFFF_FFF8, 1'b0);
    dec("allones", 32'hFFFF_FFFF, 32'h8000_001C, 4'd15, 32'h0, 1'b1);
    dec("ebreak", 32'h0010_0073, 32'h8000_0020, 4'd9, 32'h0000_0001, 1'b0);
    check("ebreak_flag", 32'(bus.out_ebreak), 32'd1);
    dec("low00", 32'h0000_0010, 32'h8000_0024, 4'd15, 32'h0, 1'b1);
    check("low00_ebreak", 32'(bus.out_ebreak), 32'd0);
    dec("jalr_f3", 32'h0000_10E7, 32'h8000_0028, 4'd3, 32'h0, 1'b1);
    dec("mul", 32'h0220_8033, 32'h8000_002C, 4'd8, 32'h0, 1'b1);
    dec("sub", 32'h4020_8033, 32'h8000_0030, 4'd8, 32'h0, 1'b0);
    check("sub_f7b5", 32'(bus.out_f7b5), 32'd1);

    // Hold: A loaded, then 3 stalled cycles with B waiting
    dec("holdA", 32'h0030_0193, 32'h0000_0100, 4'd7, 32'h3, 1'b0);
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h0040_0213, 32'h0000_0104);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_rd", 32'(bus.out_rd), 32'd3);
      check("hold_pc", bus.out_pc, 32'h0000_0100);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("holdB_rd", 32'(bus.out_rd), 32'd4);
    check("holdB_pc", bus.out_pc, 32'h0000_0104);
    check("holdB_valid", 32'(bus.out_valid), 32'd1);
    drive(1'b0, 32'h0040_0213, 32'h0000_0104);
    tick();
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    // Flush with valid bundle and incoming instruction
    dec("preflush", 32'h0050_0293, 32'h0000_0200, 4'd7, 32'h5, 1'b0);
    drive(1'b1, 32'h0060_0313, 32'h0000_0204);
    bus.flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("postflush_valid", 32'(bus.out_valid), 32'd0);
    dec("afterflush", 32'h0070_0393, 32'h0000_0300, 4'd7, 32'h7, 1'b0);
    check("afterflush_rd", 32'(bus.out_rd), 32'd7);

    // Reset while holding a bundle
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h0080_0413, 32'h0000_0304);
    tick();
    check("prerst_rd", 32'(bus.out_rd), 32'd7);
    rst = 1'b1;
    tick();
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_pc", bus.out_pc, 32'h0);
    check("midrst_imm", bus.out_imm, 32'h0);
    check("midrst_rd", 32'(bus.out_rd), 32'd0);
    check("midrst_op", 32'(bus.out_op), 32'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    check("postrst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("postrst_valid", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
